// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory between the fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise the data port always wins.
module mem_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata
);

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    localparam logic [2:0] LatCnt = 3'(MEM_LAT);

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       owner_we;
    logic       last;

    logic       resp;
    logic       free;
    logic       grant;
    logic       win;

    // The response cycle frees the arbiter so accesses can be issued back to back.
    assign resp  = (state == StBusy) && (cnt == 3'd1);
    assign free  = (state == StIdle) || resp;
    assign grant = free && (i_req || d_req);

    // win: 0 = fetch, 1 = data
    always_comb begin
        win = d_req;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            win = ~last;
`else
            win = 1'b1;
`endif
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            cnt      <= 3'd0;
            owner    <= 1'b0;
            owner_we <= 1'b0;
            last     <= 1'b0;
        end else if (grant) begin
            state    <= StBusy;
            cnt      <= LatCnt;
            owner    <= win;
            owner_we <= win & d_we;
            last     <= win;
        end else if (state == StBusy) begin
            if (cnt == 3'd1) begin
                state <= StIdle;
                cnt   <= 3'd0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_comb begin
        i_gnt   = grant & ~win;
        d_gnt   = grant & win;
        m_en    = grant;
        m_we    = 1'b0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        m_be    = 4'h0;
        if (grant && win) begin
            m_we    = d_we;
            m_addr  = {d_addr[31:2], 2'b00};
            m_wdata = d_wdata;
            m_be    = d_we ? d_be : 4'h0;
        end else if (grant) begin
            m_addr  = {i_addr[31:2], 2'b00};
        end
    end

    always_comb begin
        i_rvalid = resp & ~owner;
        d_rvalid = resp & owner;
        i_rdata  = i_rvalid ? m_rdata : 32'h0;
        d_rdata  = (d_rvalid && !owner_we) ? m_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance per MEM_LAT value (1..4) run in parallel.
module tb_mem_arbiter;

    localparam int NLAT = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input int lat, input logic [159:0] act,
                       input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d got=%0h want=%0h", tag, lat, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int k);
        case (k)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h1122_3344;
            3:       return 32'h5550_0093;
            default: return 32'h1000_0000 + k;
        endcase
    endfunction

    for (genvar gi = 0; gi < NLAT; gi++) begin : g_lat
        localparam int unsigned LAT = gi + 1;

        logic        rst_n, preload;
        logic        i_req, d_req, d_we;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic [3:0]  d_be;
        logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
        logic [31:0] i_rdata, d_rdata;
        logic        m_en, m_we;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [3:0]  m_be;
        logic [137:0] outs;
        logic [31:0] cyc = '0;
        logic [31:0] mem [16];
        logic [31:0] pipe [LAT];
        resp_t       iq[$];
        resp_t       dq[$];
        resp_t       r_i, r_d;

        mem_arbiter #(.MEM_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_req    (i_req),
            .i_addr   (i_addr),
            .i_gnt    (i_gnt),
            .i_rvalid (i_rvalid),
            .i_rdata  (i_rdata),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_be     (d_be),
            .d_gnt    (d_gnt),
            .d_rvalid (d_rvalid),
            .d_rdata  (d_rdata),
            .m_en     (m_en),
            .m_we     (m_we),
            .m_addr   (m_addr),
            .m_wdata  (m_wdata),
            .m_be     (m_be),
            .m_rdata  (m_rdata)
        );

        assign outs = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                       m_en, m_we, m_addr, m_wdata, m_be};

        always @(posedge clk) cyc <= cyc + 1;

        // Memory model: byte-masked writes, reads returned LAT cycles after m_en.
        assign m_rdata = pipe[LAT-1];
        always @(posedge clk) begin
            if (preload) begin
                for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
                for (int k = 0; k < int'(LAT); k++) pipe[k] <= 32'hDEAD_BEEF;
            end else begin
                if (m_en && m_we)
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mem[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
                pipe[0] <= (m_en && !m_we) ? mem[m_addr[5:2]] : 32'hDEAD_BEEF;
                for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
            end
        end

        // Monitor: pops the expected response whenever the DUT pulses rvalid.
        always @(negedge clk) begin
            if (i_rvalid === 1'b1) begin
                if (iq.size() == 0) chk("i_rvalid_unexpected", LAT, i_rvalid, 0);
                else begin
                    r_i = iq.pop_front();
                    chk("i_rdata", LAT, i_rdata, r_i.data);
                    chk("i_rvalid_cycle", LAT, cyc, r_i.cyc);
                end
            end else chk("i_rdata_quiet", LAT, i_rdata, 0);
            if (d_rvalid === 1'b1) begin
                if (dq.size() == 0) chk("d_rvalid_unexpected", LAT, d_rvalid, 0);
                else begin
                    r_d = dq.pop_front();
                    chk("d_rdata", LAT, d_rdata, r_d.data);
                    chk("d_rvalid_cycle", LAT, cyc, r_d.cyc);
                end
            end else chk("d_rdata_quiet", LAT, d_rdata, 0);
            if (m_en !== 1'b1) chk("m_quiet", LAT, {m_we, m_addr, m_wdata, m_be}, 0);
            chk("m_addr_align", LAT, m_addr[1:0], 0);
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input int n);
            for (int k = 0; k < n; k++) step();
        endtask

        task automatic do_access(input logic port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] exp);
            int n = 0;
            if (port) begin
                d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
            end else begin
                i_req = 1'b1; i_addr = addr;
            end
            @(negedge clk);
            while (((port ? d_gnt : i_gnt) !== 1'b1) && n < 20) begin
                step();
                @(negedge clk);
                n++;
            end
            chk("acc_gnt", LAT, port ? d_gnt : i_gnt, 1);
            chk("acc_mem", LAT, {m_en, m_we, m_addr, m_wdata, m_be},
                {1'b1, port & we, addr[31:2], 2'b00, port ? wdata : 32'h0,
                 (port & we) ? be : 4'h0});
            if (port) dq.push_back('{data: exp, cyc: cyc + LAT});
            else      iq.push_back('{data: exp, cyc: cyc + LAT});
            step();
            i_req = 1'b0;
            d_req = 1'b0;
        endtask

        initial begin
            int n, rdly;
            logic [31:0] prev;
            logic [3:0]  wins;
            rst_n = 1'b0; preload = 1'b1;
            i_req = 1'b0; i_addr = '0;
            d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
            step();
            preload = 1'b0;
            @(negedge clk);
            chk("reset_outputs", LAT, outs, 0);
            step();
            rst_n = 1'b1;

            // Single fetch from a misaligned address.
            do_access(1'b0, 1'b0, 32'h0000_000E, 32'h0, 4'h0, 32'h5550_0093);
            idle(LAT + 1);

            // Store, then a load presented right after: blocked until the response cycle.
            do_access(1'b1, 1'b1, 32'h0, 32'h555, 4'hF, 32'h0);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = '0; d_be = '0;
            for (int k = 1; k <= int'(LAT); k++) begin
                @(negedge clk);
                chk("d_busy_gnt", LAT, d_gnt, k == int'(LAT));
                if (k < int'(LAT)) step();
            end
            dq.push_back('{data: 32'h555, cyc: cyc + LAT});
            step();
            d_req = 1'b0;
            idle(LAT + 1);

            // Partial store, load it back, fetch held high through the load.
            do_access(1'b1, 1'b1, 32'h4, 32'hAAAA_BBBB, 4'b0011, 32'h0);
            idle(LAT + 1);
            do_access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h1122_BBBB);
            i_req = 1'b1; i_addr = 32'h8;
            for (int k = 1; k <= int'(LAT); k++) begin
                @(negedge clk);
                chk("i_busy_gnt", LAT, i_gnt, k == int'(LAT));
                if (k < int'(LAT)) step();
            end
            iq.push_back('{data: 32'h1000_0002, cyc: cyc + LAT});
            step();
            i_req = 1'b0;
            idle(LAT + 1);

            // Store withdrawn while busy must never reach memory.
            do_access(1'b0, 1'b0, 32'h0000_000E, 32'h0, 4'h0, 32'h5550_0093);
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'hBAD; d_be = 4'hF;
            for (int k = 1; k < int'(LAT); k++) begin
                @(negedge clk);
                chk("withdraw_gnt", LAT, {d_gnt, m_en}, 0);
                step();
            end
            d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = '0;
            idle(LAT + 1);
            do_access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h555);
            idle(LAT + 1);

            // Contention straight after reset.
            rst_n = 1'b0;
            idle(2);
            rst_n = 1'b1;
`ifdef MEM_ARB_RR_EN
            wins = 4'b0101;
`else
            wins = 4'b1111;
`endif
            i_req = 1'b1; i_addr = 32'h8;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0; d_be = '0;
            prev = '0;
            for (int j = 0; j < 4; j++) begin
                n = 0;
                @(negedge clk);
                while ((i_gnt | d_gnt) !== 1'b1 && n < 20) begin
                    step();
                    @(negedge clk);
                    n++;
                end
                chk("cont_winner", LAT, {i_gnt, d_gnt}, wins[j] ? 2'b01 : 2'b10);
                if (j > 0) chk("cont_spacing", LAT, cyc - prev, LAT);
                prev = cyc;
                if (wins[j]) dq.push_back('{data: 32'h1000_0004, cyc: cyc + LAT});
                else         iq.push_back('{data: 32'h1000_0002, cyc: cyc + LAT});
                step();
            end
            i_req = 1'b0; d_req = 1'b0;
            idle(LAT + 1);

            // Reset during an outstanding fetch: its response is dropped.
            i_req = 1'b1; i_addr = 32'h8;
            @(negedge clk);
            chk("rst_fetch_gnt", LAT, i_gnt, 1);
            rdly = (LAT > 2) ? 2 : int'(LAT) - 1;
            for (int k = 0; k < rdly; k++) begin
                step();
                i_req = 1'b0;
            end
            i_req = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("rst_async_outputs", LAT, outs, 0);
            idle(2);
            @(negedge clk);
            chk("rst_hold_outputs", LAT, outs, 0);
            step();
            rst_n = 1'b1;
            i_req = 1'b1; i_addr = 32'h0000_000E;
            @(negedge clk);
            chk("rst_release_gnt", LAT, i_gnt, 1);
            iq.push_back('{data: 32'h5550_0093, cyc: cyc + LAT});
            step();
            i_req = 1'b0;
            idle(LAT + 3);

            chk("iq_drained", LAT, iq.size(), 0);
            chk("dq_drained", LAT, dq.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        wait (done_cnt == NLAT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single word-addressed program/data memory between the instruction-fetch port and the load/store port of the RISC-V core. Each requester uses a req/gnt handshake with a fixed-latency response pulse. The block tracks one outstanding memory access at a time and steers the read data back to the requester that owns it. It sits between the core's fetch and LSU stages and the memory macro, whose read data appears `MEM_LAT` cycles after an enabled access.

## Interface
- `MEM_LAT`, default 1: cycles from the `m_en` cycle to valid `m_rdata`; legal range 1..4.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `i_req` input 1: fetch request; held high until granted.
- `i_addr` input 32: fetch byte address.
- `i_gnt` output 1: fetch request accepted this cycle.
- `i_rvalid` output 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` output 32: fetched instruction word.
- `d_req` input 1: data request; held high until granted.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address.
- `d_wdata` input 32: store data.
- `d_be` input 4: store byte enables.
- `d_gnt` output 1: data request accepted this cycle.
- `d_rvalid` output 1: one-cycle completion pulse, for loads and stores.
- `d_rdata` output 32: load data; 0 for stores.
- `m_en` output 1: memory access strobe.
- `m_we` output 1: memory write.
- `m_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `m_wdata` output 32: memory write data.
- `m_be` output 4: memory byte enables; 4'b0000 on reads.
- `m_rdata` input 32: memory read data.

## Operation
- State machine with two states:
  - IDLE: no access outstanding.
  - BUSY: access outstanding; a down-counter `cnt` (3 bits) holds the cycles remaining.
  - Registers: `owner` (0 = fetch, 1 = data) and `last` (last granted port).
- Grant is combinational when the arbiter is "free". Free means state IDLE, or state BUSY with `cnt == 1`, which is the response cycle.
- Selection when free:
  - Only one req high: that port wins.
  - Both req high: decided by arbitration policy (see Configuration).
  - Neither req high: no grant.
- In the grant cycle:
  - `m_en=1`; `m_we`, `m_addr`, `m_wdata`, `m_be` are driven from the winner.
  - The winner's `*_gnt=1`.
  - Fetch grants force `m_we=0` and `m_be=0`.
- When `m_en=0`, all `m_*` outputs are 0.
- On each grant, at the next edge: state ← BUSY, `cnt` ← `MEM_LAT`, `owner` ← winner, `last` ← winner.
- In BUSY, `cnt` decrements each cycle.
- Response cycle (`cnt == 1`):
  - `owner`'s `*_rvalid=1`.
  - `*_rdata = m_rdata` for reads; 0 for stores.
  - The non-owner's rdata is 0.
  - The next edge goes to IDLE unless a new grant occurs in the same cycle, in which case BUSY is reloaded.
- Store completion uses the same latency as a load; no read data is returned.
- Requesters must hold addr, data, `we` and `be` stable while req is high and gnt is low. Dropping req before gnt is legal and simply withdraws the request.
- `m_addr[1:0]` is always 0; misalignment checking is the LSU's responsibility.

## Timing
- Reset (asynchronous, `rst_n=0`):
  - state ← IDLE, `cnt` ← 0, `owner` ← 0, `last` ← 0 (fetch).
  - All outputs read 0 while reset is asserted and no req is high.
- Grant latency: 0 cycles. req high in cycle N with the arbiter free gives gnt in cycle N.
- Response latency: grant in cycle N gives rvalid in cycle N+`MEM_LAT`, for exactly one cycle.
- Throughput: one access per `MEM_LAT` cycles; back-to-back grants are allowed in the response cycle. `MEM_LAT=1` gives one access per cycle.
- Reset mid-access: the outstanding response is discarded and no rvalid is issued after reset deasserts.
- While BUSY with `cnt > 1`, both gnts are 0 regardless of req.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention the port ≠ `last` wins. After reset, the first contention goes to data.
- `MEM_ARB_RR_EN` undefined: fixed priority, data port wins every contention. `last` is still maintained but unused for selection.

## Test plan
- Single fetch, `MEM_LAT=1`:
  - Stimulus: `i_req=1`, `i_addr=32'h0000000E` in cycle 0; memory returns 32'h555000 93.
  - Response: `i_gnt=1` and `m_addr=32'h0000000C` in cycle 0; `i_rvalid=1` and `i_rdata=32'h55500093` in cycle 1.
- Store then load, `MEM_LAT=2`:
  - Stimulus: `d_we=1`, `d_addr=32'h0`, `d_wdata=32'h555`, `d_be=4'hF`.
  - Response: `m_we=1` and `m_be=4'hF` in the grant cycle; `d_rvalid=1` with `d_rdata=0` two cycles later, with the next load granted in that same cycle.
- Contention, both req high for 4 accesses, `MEM_LAT=1`:
  - Without `MEM_ARB_RR_EN`: grants D,D,D,D.
  - With `MEM_ARB_RR_EN`: grants D,I,D,I.
- Busy blocking, `MEM_LAT=3`:
  - Stimulus: `i_req` held high through a data access.
  - Response: `i_gnt=0` in the 2 cycles after the data grant; `i_gnt=1` in the cycle `d_rvalid` pulses.
- Reset mid-access, `MEM_LAT=4`:
  - Stimulus: `rst_n` pulsed low 2 cycles after a fetch grant.
  - Response: no `i_rvalid` afterwards; all outputs 0 during reset; the next request is granted immediately after reset deasserts.
- Request withdrawal:
  - Stimulus: `d_req` dropped while BUSY before its gnt.
  - Response: no `d_gnt` and no memory write occurs.
